// File: rtl/hazard_pipe.sv
// Issue-to-writeback tracking pipeline: carries rd/we/mem per in-flight instruction,
// drives the register-file write port, forwards operands and raises the load-use stall.
module hazard_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [REGW-1:0] issue_rd,
  input  logic            issue_we,
  input  logic            issue_mem,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] mem_result,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] src1_data,
  output logic [XLEN-1:0] src2_data,
  output logic            wb_en,
  output logic [REGW-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);

  typedef struct packed {
    logic            haz;
    logic [XLEN-1:0] data;
  } fwd_t;

  // Index 0 is S1 (youngest), index DEPTH-1 is S`DEPTH` (writeback).
  logic            v_q    [DEPTH];
  logic [REGW-1:0] rd_q   [DEPTH];
  logic            we_q   [DEPTH];
  logic            mem_q  [DEPTH];
  logic [XLEN-1:0] data_q [1:DEPTH-1];

  logic [DEPTH-1:0] live;
  fwd_t             fwd1;
  fwd_t             fwd2;

  always_comb begin
    live = '0;
    for (int k = 0; k < DEPTH; k++) begin
      live[k] = v_q[k] & we_q[k] & (rd_q[k] != '0);
    end
  end

  assign wb_en   = live[DEPTH-1];
  assign wb_rd   = rd_q[DEPTH-1];
  assign wb_data = mem_q[DEPTH-1] ? mem_result : data_q[DEPTH-1];

  // Scan oldest to youngest so the youngest matching stage overrides older ones.
  function automatic fwd_t lookup(input logic [REGW-1:0] rs, input logic [XLEN-1:0] rdata);
    fwd_t r;
    r.haz  = 1'b0;
    r.data = rdata;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (live[k] && (rd_q[k] == rs)) begin
        if (k == DEPTH - 1) begin
          r.haz  = 1'b0;
          r.data = wb_data;
        end else if (mem_q[k]) begin
          r.haz = 1'b1;
        end else begin
          r.haz  = 1'b0;
          r.data = data_q[k];
        end
      end
    end
    if (live[0] && (rd_q[0] == rs)) begin
      if (mem_q[0]) begin
        r.haz = 1'b1;
      end else begin
        r.haz  = 1'b0;
        r.data = ex_result;
      end
    end
    return r;
  endfunction

  always_comb begin
    fwd1 = lookup(rs1, rf_rdata1);
    fwd2 = lookup(rs2, rf_rdata2);
  end

  assign src1_data = fwd1.data;
  assign src2_data = fwd2.data;
  assign stall     = issue_valid & ~flush & (fwd1.haz | fwd2.haz);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]   <= 1'b0;
        rd_q[k]  <= '0;
        we_q[k]  <= 1'b0;
        mem_q[k] <= 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q[0]   <= issue_valid & ~stall & ~flush;
      rd_q[0]  <= issue_rd;
      we_q[0]  <= issue_we;
      mem_q[0] <= issue_mem;
      // Flush squashes the S1 instruction on its way into S2.
      v_q[1]    <= v_q[0] & ~flush;
      rd_q[1]   <= rd_q[0];
      we_q[1]   <= we_q[0];
      mem_q[1]  <= mem_q[0];
      data_q[1] <= ex_result;
      for (int k = 2; k < DEPTH; k++) begin
        v_q[k]    <= v_q[k-1];
        rd_q[k]   <= rd_q[k-1];
        we_q[k]   <= we_q[k-1];
        mem_q[k]  <= mem_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

endmodule
